// File: rtl/mux_2_1_reg_pkg.sv
// Shared constants and helpers for the 2:1 select cells and the n:1 select tree
// that is built from them.
package mux_2_1_reg_pkg;

   // Default data word width of one select stage.
   localparam int MUX_DEFAULT_WIDTH = 8;

   // Packed input width of a 2:1 stage: two words side by side.
   function automatic int packed_in_width(input int w);
      return 2 * w;
   endfunction

endpackage : mux_2_1_reg_pkg

// File: rtl/mux_2_1_comb.sv
// Pure combinational 2:1 word select.
// word0 is data_in[WIDTH-1:0] and word1 is data_in[2*WIDTH-1:WIDTH].
// Bit order inside the chosen word is passed through unchanged.
module mux_2_1_comb
   import mux_2_1_reg_pkg::*;
#(
   parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
   input  logic                 sel,
   input  logic [2*WIDTH-1:0]   data_in,
   output logic [WIDTH-1:0]     word
);

   // Pick the lower word by default, override with the upper word when sel=1.
   always_comb begin
      // NOTE: assign a default before any condition so every path drives 'word'; otherwise a latch is inferred.
      word = data_in[WIDTH-1:0];
      if (sel) begin
         word = data_in[2*WIDTH-1:WIDTH];
      end
   end

endmodule : mux_2_1_comb

// File: rtl/mux_2_1_reg.sv
// Registered 2:1 word multiplexer with a valid qualifier: the selected word
// appears on data_out exactly one clock after it is presented with in_valid.
// Leaf cell of the n:1 select tree; also usable on its own.
//
// Optional build macro MUX_2_1_SEL_CHECK_EN: adds a simulation-only checker
// that flags an unknown sel on valid cycles and rejects inconsistent width
// parameters at elaboration. It adds no synthesized logic.
module mux_2_1_reg
   import mux_2_1_reg_pkg::*;
#(
   parameter int WIDTH     = MUX_DEFAULT_WIDTH,
   parameter int IN_WIDTH  = packed_in_width(WIDTH),
   parameter int OUT_WIDTH = WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sel,
   input  logic [IN_WIDTH-1:0]  data_in,
   input  logic                 in_valid,
   output logic [OUT_WIDTH-1:0] data_out,
   output logic                 out_valid
);

   logic [WIDTH-1:0] sel_word;

   mux_2_1_comb #(
      .WIDTH (WIDTH)
   ) u_select (
      .sel     (sel),
      .data_in (data_in),
      .word    (sel_word)
   );

   // Output register: reset wins, valid words are captured, otherwise data holds and valid drops.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is always updated with non-blocking (<=) assignments.
      if (reset) begin
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            data_out <= sel_word;
         end
      end
   end

`ifdef MUX_2_1_SEL_CHECK_EN
   // The packed widths only make sense as two words in and one word out.
   if (IN_WIDTH != 2 * WIDTH || OUT_WIDTH != WIDTH) begin : g_width_check
      $fatal(1, "mux_2_1_reg: IN_WIDTH must be 2*WIDTH and OUT_WIDTH must be WIDTH");
   end

   // Flag an unknown select on any cycle where the input word is going to be captured.
   always @(posedge clk) begin
      if (!reset && in_valid && $isunknown(sel)) begin
         $error("mux_2_1_reg: sel is X/Z on a valid input cycle");
      end
   end
`endif

endmodule : mux_2_1_reg

// File: tb/tb_mux_2_1_reg.sv
// Directed bench for mux_2_1_reg: an 8-bit instance and a 1-bit instance.
// Each driven cycle pushes the expected output into a scoreboard queue; the
// entry is popped and compared on the falling edge after the capturing edge.
module tb_mux_2_1_reg;

   typedef struct {
      logic [7:0] data;
      logic       valid;
   } exp_t;

   logic        clk = 1'b0;

   // 8-bit instance signals
   logic        reset8    = 1'b1;
   logic        sel8      = 1'b0;
   logic [15:0] din8      = '0;
   logic        vld8      = 1'b0;
   logic [7:0]  dout8;
   logic        ovld8;

   // 1-bit instance signals
   logic        reset1    = 1'b1;
   logic        sel1      = 1'b0;
   logic [1:0]  din1      = '0;
   logic        vld1      = 1'b0;
   logic [0:0]  dout1;
   logic        ovld1;

   exp_t sb8[$];
   exp_t sb1[$];

   // Reference state: the word data_out is expected to hold.
   logic [7:0] model8 = '0;
   logic [0:0] model1 = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_2_1_reg #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .reset     (reset8),
      .sel       (sel8),
      .data_in   (din8),
      .in_valid  (vld8),
      .data_out  (dout8),
      .out_valid (ovld8)
   );

   mux_2_1_reg #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .reset     (reset1),
      .sel       (sel1),
      .data_in   (din1),
      .in_valid  (vld1),
      .data_out  (dout1),
      .out_valid (ovld1)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle into the 8-bit instance, predict, then compare after the edge.
   task automatic step8(input string tag, input logic rst, input logic vld,
                        input logic s, input logic [15:0] din);
      exp_t e;
      reset8 = rst;
      vld8   = vld;
      sel8   = s;
      din8   = din;
      if (rst) begin
         model8 = 8'h00;
         e.valid = 1'b0;
      end else if (vld) begin
         model8 = s ? din[15:8] : din[7:0];
         e.valid = 1'b1;
      end else begin
         e.valid = 1'b0;
      end
      e.data = model8;
      sb8.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (sb8.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb8.pop_front();
         check({tag, ".data"},  dout8, e.data);
         check({tag, ".valid"}, {7'd0, ovld8}, {7'd0, e.valid});
      end
   endtask

   // Same for the 1-bit instance.
   task automatic step1(input string tag, input logic rst, input logic vld,
                        input logic s, input logic [1:0] din);
      exp_t e;
      reset1 = rst;
      vld1   = vld;
      sel1   = s;
      din1   = din;
      if (rst) begin
         model1 = 1'b0;
         e.valid = 1'b0;
      end else if (vld) begin
         model1 = s ? din[1] : din[0];
         e.valid = 1'b1;
      end else begin
         e.valid = 1'b0;
      end
      e.data = {7'd0, model1};
      sb1.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (sb1.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb1.pop_front();
         check({tag, ".data"},  {7'd0, dout1}, e.data);
         check({tag, ".valid"}, {7'd0, ovld1}, {7'd0, e.valid});
      end
   endtask

   // Run-time bound so the bench always ends on its own.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] r;
      @(negedge clk);

      // Reset held two cycles with a valid word present.
      step8("rst0", 1'b1, 1'b1, 1'b0, 16'hA55A);
      step8("rst1", 1'b1, 1'b1, 1'b1, 16'hA55A);

      // Select low / high, then streaming 0,1,0.
      step8("sel_lo", 1'b0, 1'b1, 1'b0, 16'hBEEF);
      step8("sel_hi", 1'b0, 1'b1, 1'b1, 16'hBEEF);
      step8("strm0",  1'b0, 1'b1, 1'b0, 16'hBEEF);
      step8("strm1",  1'b0, 1'b1, 1'b1, 16'hBEEF);
      step8("strm2",  1'b0, 1'b1, 1'b0, 16'hBEEF);
      step8("to_be",  1'b0, 1'b1, 1'b1, 16'hBEEF);

      // Hold: invalid cycles with changing sel/data must not disturb data_out.
      step8("hold0", 1'b0, 1'b0, 1'b0, 16'h1234);
      step8("hold1", 1'b0, 1'b0, 1'b1, 16'h1234);
      step8("hold2", 1'b0, 1'b0, 1'b0, 16'h1234);

      // Reset has priority over a valid input on the same edge.
      step8("rst_prio", 1'b1, 1'b1, 1'b1, 16'hFFFF);

      // All-ones and all-zero words pass unchanged.
      step8("ones_lo",  1'b0, 1'b1, 1'b0, 16'hFFFF);
      step8("zeros_hi", 1'b0, 1'b1, 1'b1, 16'h0000);
      step8("mixed_hi", 1'b0, 1'b1, 1'b1, 16'hFF00);

      // Mid-stream reset discards the in-flight word; stream resumes afterwards.
      step8("mid_v",   1'b0, 1'b1, 1'b0, 16'h5A3C);
      step8("mid_rst", 1'b1, 1'b1, 1'b1, 16'h5A3C);
      step8("resume",  1'b0, 1'b1, 1'b1, 16'h5A3C);

      // A short random valid/invalid mix.
      for (int i = 0; i < 16; i++) begin
         r = 16'($urandom);
         step8("rand", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r);
      end

      // One-bit instance.
      step1("w1_rst",  1'b1, 1'b1, 1'b1, 2'b11);
      step1("w1_hi",   1'b0, 1'b1, 1'b1, 2'b10);
      step1("w1_lo",   1'b0, 1'b1, 1'b0, 2'b10);
      step1("w1_lo1",  1'b0, 1'b1, 1'b0, 2'b01);
      step1("w1_hold", 1'b0, 1'b0, 1'b1, 2'b00);
      step1("w1_hi0",  1'b0, 1'b1, 1'b1, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mux_2_1_reg
